uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Parametrised UART receiver.
- Successor to the fixed 8N1 receive path; sits between the board's UART RX pin and the command and loopback logic.
- Configurable data width, stop-bit count and baud divisor, with false-start rejection.
- Reports framing, overrun and (optionally) parity errors through a valid/ready output handshake.

Parameters:
- CLK_FREQ, 50_000_000: clk_in frequency in Hz.
- UART_BAUD, 115200: line baud rate.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.
- PARITY_ODD, 0: 1 = odd parity, 0 = even parity. Used only when UART_RX_PARITY_EN is defined.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- uart_rx_path  input  1  serial line; asynchronous; idles high.
- rx_data  output  DATA_BITS  received word, LSB = first bit on the line.
- rx_valid  output  1  rx_data holds a word not yet consumed.
- rx_ready  input  1  consumer accepts the word.
- frame_err  output  1  frame error flag; qualified by rx_valid.
- parity_err  output  1  parity error flag; qualified by rx_valid; tied 0 without UART_RX_PARITY_EN.
- overrun  output  1  sticky; set when a frame completes while rx_valid=1 and rx_ready=0.
- overrun_clr  input  1  clears overrun.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous and active-low on rst_n_in.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0, state=IDLE, all counters 0, synchroniser flops = 1.
- Divisors: BAUD_DIV = CLK_FREQ/UART_BAUD (integer). HALF_DIV = BAUD_DIV/2. The baud counter is 16 bits wide.
- Input sync: uart_rx_path passes through a 2-flop synchroniser (rx_s). All references below use rx_s.
- IDLE: rx_s=0 starts a frame. Go to START, clear the baud counter.
- START: count to HALF_DIV-1, then sample rx_s.
  - Sample 1 -> false start; return to IDLE with no output and no flags.
  - Sample 0 -> go to DATA, bit index 0, baud counter 0.
- DATA: every BAUD_DIV cycles, sample rx_s into shift bit[index] (LSB first), then increment index.
  - After bit DATA_BITS-1: go to PARITY if UART_RX_PARITY_EN is defined, otherwise go to STOP.
- PARITY: one bit period. The sampled bit is compared with the XOR of the data bits; for odd parity the expected value is inverted. A mismatch latches a pending parity error.
- STOP: one sample per stop bit at bit centre. Any stop sample equal to 0 latches a pending frame error.
- Frame completion: after the last stop sample, in the next cycle:
  - rx_data, frame_err and parity_err load.
  - rx_valid=1.
  - state returns to IDLE immediately, at mid-stop, so a back-to-back start bit is caught.
- Handshake:
  - rx_valid stays high, with data and flags stable, until the cycle where rx_valid and rx_ready are both 1.
  - rx_valid drops on the next edge.
  - A completion in the same cycle as an accept loads the new word and holds rx_valid=1.
- Overrun: a completion while rx_valid=1 and rx_ready=0 leaves the old word intact, discards the new word and sets overrun.
  - overrun_clr=1 clears overrun on the next edge.
  - A set event in the same cycle as overrun_clr wins: overrun stays 1.
- Framing error: a frame with frame_err=1 is still delivered; there is no resynchronisation wait. A line held low re-enters START after the stop centre, giving repeated frames of all-zero data with frame_err=1.
- Mid-frame reset: asserting rst_n_in mid-frame aborts the frame immediately. No partial word is ever delivered.
- Latency: rx_valid rises 1 cycle after the final stop-bit centre sample.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: the PARITY state is present, frames carry one parity bit after the data bits, and parity_err is checked as described above.
- Undefined: no PARITY state, frames are data bits followed by stop bits, and parity_err is constant 0.

Test Plan:
- 8N1, 50 MHz / 115200 (BAUD_DIV=434): send 0xA5 with rx_ready=1. Expect rx_data=0xA5, frame_err=0, and rx_valid high for exactly 1 cycle, about 9.5×434 cycles after the start edge.
- Glitch: drive uart_rx_path low for 100 cycles, then high. Expect rx_valid never rises and busy returns to 0 before cycle 220.
- Bad stop: send 0x3C with the stop bit driven low. Expect rx_data=0x3C and frame_err=1.
- Overrun: send 0x11 then 0x22 back-to-back with rx_ready=0. Expect rx_data=0x11 and overrun=1. Pulse overrun_clr, expect overrun=0. Pulse rx_ready, expect rx_valid=0.
- DATA_BITS=7, STOP_BITS=2, UART_RX_PARITY_EN defined, PARITY_ODD=1: send 0x55 with correct parity bit 1. Expect parity_err=0. Resend with parity bit 0, expect parity_err=1.
- Reset mid-frame: assert rst_n_in low during data bit 4, release, then send 0x81. Expect exactly one rx_valid, with rx_data=0x81.

Source files
------------

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: 2-flop input sync, false-start rejection, valid/ready output with
// framing/overrun flags. Define UART_RX_PARITY_EN to add a parity bit (odd/even via PARITY_ODD).
module uart_rx_core #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BAUD  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 uart_rx_path,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 overrun_clr,
    output logic                 busy
);

    localparam int          BAUD_DIV  = CLK_FREQ / UART_BAUD;
    localparam int          HALF_DIV  = BAUD_DIV / 2;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_DIV - 1);
    localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_cfg
        $error("uart_rx_core: illegal DATA_BITS/STOP_BITS/PARITY_ODD");
    end

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP
`ifdef UART_RX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t               state, state_nxt;
    logic [15:0]          cnt, cnt_nxt;
    logic [3:0]           idx, idx_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic                 ferr_pend, ferr_nxt;
    logic                 done_p0, done_nxt;
    logic                 rx_meta_p0, rx_s;
`ifdef UART_RX_PARITY_EN
    localparam logic      PAR_INV = 1'(PARITY_ODD);
    logic                 perr_pend, perr_nxt;
`endif

    // Input synchroniser: the line idles high, so the flops reset to 1
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_meta_p0 <= 1'b1;
            rx_s       <= 1'b1;
        end else begin
            rx_meta_p0 <= uart_rx_path;
            rx_s       <= rx_meta_p0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            ferr_pend <= 1'b0;
            done_p0   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_pend <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            shift     <= shift_nxt;
            ferr_pend <= ferr_nxt;
            done_p0   <= done_nxt;
`ifdef UART_RX_PARITY_EN
            perr_pend <= perr_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 16'd1;
        idx_nxt   = idx;
        shift_nxt = shift;
        ferr_nxt  = ferr_pend;
        done_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_nxt  = perr_pend;
`endif
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
                    perr_nxt  = 1'b0;
`endif
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BAUD_LAST) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
                    idx_nxt   = idx + 4'd1;
                    if (idx == DATA_LAST) begin
                        idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == BAUD_LAST) begin
                    cnt_nxt   = '0;
                    perr_nxt  = rx_s ^ (^shift) ^ PAR_INV;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == BAUD_LAST) begin
                    cnt_nxt  = '0;
                    ferr_nxt = ferr_pend | ~rx_s;
                    idx_nxt  = idx + 4'd1;
                    // Back to IDLE at mid-stop so an immediately following start bit is caught
                    if (idx == STOP_LAST) begin
                        idx_nxt   = '0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output stage: a completing frame is dropped (and overrun raised) if the old word is still held
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (done_p0 && (!rx_valid || rx_ready)) begin
                rx_data   <= shift;
                frame_err <= ferr_pend;
                rx_valid  <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid  <= 1'b0;
            end
            if (done_p0 && rx_valid && !rx_ready) overrun <= 1'b1;
            else if (overrun_clr)                 overrun <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)                               parity_err <= 1'b0;
        else if (done_p0 && (!rx_valid || rx_ready)) parity_err <= perr_pend;
    end
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: a frame-level model predicts rx_valid/data/flags/overrun each cycle,
// and directed checks pin latency, glitch rejection, framing, overrun, parity and mid-frame reset.
module tb_uart_rx_core;

`ifdef UART_RX_PARITY_EN
    localparam int DB = 7, SB = 2, PO = 1, PB = 1, RISE_LIT = 4560;
`else
    localparam int DB = 8, SB = 1, PO = 0, PB = 0, RISE_LIT = 4126;
`endif
    localparam int BAUD = 434;   // 50 MHz / 115200
    localparam int HALF = 217;
    localparam logic [8:0] MASK = 9'((1 << DB) - 1);

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          uart_rx_path = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b1;
    logic          frame_err, parity_err, overrun, busy;
    logic          overrun_clr = 1'b0;

    uart_rx_core #(
        .CLK_FREQ(50_000_000), .UART_BAUD(115200),
        .DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(PO)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .uart_rx_path(uart_rx_path),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun),
        .overrun_clr(overrun_clr), .busy(busy)
    );

    always #10 clk_in = ~clk_in;

    typedef struct {
        int         due;
        logic [8:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic       e_valid = 1'b0, e_fe = 1'b0, e_pe = 1'b0, e_ovr = 1'b0;
    logic [8:0] e_data = '0;
    int         vcount = 0, rise_cyc = 0, run = 0, last_run = 0;
    logic [8:0] last_data = '0;
    logic       last_fe = 1'b0, last_pe = 1'b0, prev_v = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: each sent frame becomes visible on a known cycle; handshake/overrun rules applied there
    initial begin
        exp_t f;
        logic done, set_ovr;
        forever begin
            @(posedge clk_in);
            cyc = cyc + 1;
            if (!rst_n_in) begin
                q.delete();
                e_valid = 1'b0; e_data = '0; e_fe = 1'b0; e_pe = 1'b0; e_ovr = 1'b0;
            end else begin
                done = (q.size() > 0) && (q[0].due == cyc);
                if (done) f = q.pop_front();
                set_ovr = done && e_valid && !rx_ready;
                if (done && !set_ovr) begin
                    e_valid = 1'b1; e_data = f.data; e_fe = f.fe; e_pe = f.pe;
                end else if (e_valid && rx_ready) begin
                    e_valid = 1'b0;
                end
                if (set_ovr)          e_ovr = 1'b1;
                else if (overrun_clr) e_ovr = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_in);
            if (rst_n_in) begin
                chk("rx_valid", 32'(rx_valid), 32'(e_valid));
                chk("overrun", 32'(overrun), 32'(e_ovr));
                if (e_valid) begin
                    chk("rx_data", 32'(rx_data), 32'(e_data));
                    chk("frame_err", 32'(frame_err), 32'(e_fe));
                    chk("parity_err", 32'(parity_err), 32'(e_pe));
                end
                if (rx_valid && !prev_v) begin
                    vcount = vcount + 1;
                    rise_cyc = cyc;
                    last_data = 9'(rx_data);
                    last_fe = frame_err;
                    last_pe = parity_err;
                end
                if (rx_valid) run = run + 1;
                else if (run != 0) begin
                    last_run = run;
                    run = 0;
                end
                prev_v = rx_valid;
            end else begin
                prev_v = 1'b0;
                run = 0;
            end
        end
    end

    task automatic send_frame(input logic [8:0] d, input bit bad_stop, input bit bad_par, output int p0);
        exp_t e;
        logic par;
        @(negedge clk_in);
        uart_rx_path = 1'b0;
        p0 = cyc + 1;
        e.due  = p0 + 3 + HALF + (DB + PB + SB) * BAUD;
        e.data = d & MASK;
        e.fe   = bad_stop;
        e.pe   = (PB != 0) ? bad_par : 1'b0;
        q.push_back(e);
        repeat (BAUD) @(negedge clk_in);
        par = 1'(PO);
        for (int i = 0; i < DB; i++) begin
            uart_rx_path = d[i];
            par = par ^ d[i];
            repeat (BAUD) @(negedge clk_in);
        end
        if (PB != 0) begin
            uart_rx_path = par ^ bad_par;
            repeat (BAUD) @(negedge clk_in);
        end
        uart_rx_path = !bad_stop;
        repeat (SB * BAUD) @(negedge clk_in);
        uart_rx_path = 1'b1;
    endtask

    initial begin
        int p0;
        logic [8:0] d;
        repeat (4) @(negedge clk_in);
        chk("reset rx_valid", 32'(rx_valid), 32'd0);
        chk("reset rx_data", 32'(rx_data), 32'd0);
        chk("reset frame_err", 32'(frame_err), 32'd0);
        chk("reset parity_err", 32'(parity_err), 32'd0);
        chk("reset overrun", 32'(overrun), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        rst_n_in = 1'b1;
        repeat (10) @(negedge clk_in);

        // Single frame, consumer always ready
        vcount = 0;
        send_frame(9'h0A5, 1'b0, 1'b0, p0);
        repeat (20) @(negedge clk_in);
        chk("a5 count", 32'(vcount), 32'd1);
        chk("a5 data", 32'(last_data), 32'(9'h0A5 & MASK));
        chk("a5 frame_err", 32'(last_fe), 32'd0);
        chk("a5 latency", 32'(rise_cyc - p0), 32'(RISE_LIT));
        chk("a5 valid width", 32'(last_run), 32'd1);

        // Glitch shorter than half a bit
        vcount = 0;
        @(negedge clk_in);
        uart_rx_path = 1'b0;
        p0 = cyc + 1;
        repeat (100) @(negedge clk_in);
        uart_rx_path = 1'b1;
        while (cyc < p0 + 219) @(negedge clk_in);
        chk("glitch busy", 32'(busy), 32'd0);
        repeat (2 * BAUD) @(negedge clk_in);
        chk("glitch count", 32'(vcount), 32'd0);

        // Stop bit held low
        vcount = 0;
        send_frame(9'h03C, 1'b1, 1'b0, p0);
        repeat (BAUD) @(negedge clk_in);
        chk("badstop count", 32'(vcount), 32'd1);
        chk("badstop data", 32'(last_data), 32'(9'h03C & MASK));
        chk("badstop frame_err", 32'(last_fe), 32'd1);

        // Overrun with consumer stalled
        rx_ready = 1'b0;
        send_frame(9'h011, 1'b0, 1'b0, p0);
        send_frame(9'h022, 1'b0, 1'b0, p0);
        repeat (20) @(negedge clk_in);
        chk("ovr valid", 32'(rx_valid), 32'd1);
        chk("ovr data", 32'(rx_data), 32'(9'h011 & MASK));
        chk("ovr set", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        @(negedge clk_in);
        overrun_clr = 1'b0;
        chk("ovr cleared", 32'(overrun), 32'd0);
        rx_ready = 1'b1;
        @(negedge clk_in);
        rx_ready = 1'b0;
        chk("ovr accepted", 32'(rx_valid), 32'd0);
        rx_ready = 1'b1;
        repeat (BAUD) @(negedge clk_in);

`ifdef UART_RX_PARITY_EN
        send_frame(9'h055, 1'b0, 1'b0, p0);
        repeat (20) @(negedge clk_in);
        chk("par good data", 32'(last_data), 32'h55);
        chk("par good err", 32'(last_pe), 32'd0);
        send_frame(9'h055, 1'b0, 1'b1, p0);
        repeat (20) @(negedge clk_in);
        chk("par bad err", 32'(last_pe), 32'd1);
`endif

        // Reset in the middle of data bit 4
        vcount = 0;
        d = 9'h05A;
        @(negedge clk_in);
        uart_rx_path = 1'b0;
        repeat (BAUD) @(negedge clk_in);
        for (int i = 0; i < 4; i++) begin
            uart_rx_path = d[i];
            repeat (BAUD) @(negedge clk_in);
        end
        uart_rx_path = d[4];
        repeat (HALF) @(negedge clk_in);
        chk("midframe busy", 32'(busy), 32'd1);
        rst_n_in = 1'b0;
        uart_rx_path = 1'b1;
        repeat (5) @(negedge clk_in);
        chk("inreset valid", 32'(rx_valid), 32'd0);
        chk("inreset busy", 32'(busy), 32'd0);
        rst_n_in = 1'b1;
        repeat (2 * BAUD) @(negedge clk_in);
        chk("postreset count", 32'(vcount), 32'd0);
        send_frame(9'h081, 1'b0, 1'b0, p0);
        repeat (20) @(negedge clk_in);
        chk("81 count", 32'(vcount), 32'd1);
        chk("81 data", 32'(last_data), 32'(9'h081 & MASK));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
